// File: rtl/riscv_sim_monitor.sv
// Run monitor beside a RISC-V core: cycle/instret counters, halt FSM (ECALL, EBREAK,
// watchdog, stuck PC) and a circular trace of the last TRACE_DEPTH retirements.
module riscv_sim_monitor #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TRACE_DEPTH    = 16,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned STUCK_LIMIT    = 64,
  parameter bit          HALT_ON_EBREAK = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           instr_valid,
  input  logic [XLEN-1:0]                pc_in,
  input  logic [31:0]                    instr_in,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_rd_idx,
  output logic [XLEN-1:0]                trace_rd_pc,
  output logic [31:0]                    trace_rd_instr,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               instret_count,
  output logic                           running,
  output logic                           halted,
  output logic                           halt_pulse,
  output logic [1:0]                     halt_cause,
  output logic                           stuck,
  output logic [XLEN-1:0]                halt_pc
);

  localparam int unsigned IdxW = $clog2(TRACE_DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  localparam logic [31:0] InstrEcall  = 32'h0000_0073;
  localparam logic [31:0] InstrEbreak = 32'h0010_0073;

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cycle_q, instret_q;
  logic [IdxW-1:0]   wr_ptr_q;
  logic [CntW-1:0]   trace_cnt_q;
  logic [XLEN-1:0]   prev_pc_q;
  logic              prev_valid_q;
  logic [31:0]       stuck_cnt_q;
  logic [1:0]        cause_q, cause_d;
  logic              stuck_q, stuck_d;
  logic [XLEN-1:0]   halt_pc_q, halt_pc_d;
  logic              pulse_q, pulse_d;

  logic [XLEN-1:0]   mem_pc    [TRACE_DEPTH];
  logic [31:0]       mem_instr [TRACE_DEPTH];

  logic              active, retire, pc_match;
  logic [CNT_W-1:0]  cycle_inc;
  logic [31:0]       stuck_inc;
  logic              evt_ecall, evt_ebreak, evt_stuck, evt_timeout;
  logic [IdxW-1:0]   rd_ptr;

  assign active    = enable && (state_q != StHalted);
  assign retire    = active && instr_valid;
  assign cycle_inc = cycle_q + CNT_W'(1);
  assign stuck_inc = stuck_cnt_q + 32'd1;
  // prev_valid_q keeps the very first retirement from matching the reset PC
  assign pc_match  = prev_valid_q && (pc_in == prev_pc_q);

  assign evt_ecall   = retire && (instr_in == InstrEcall);
  assign evt_ebreak  = retire && HALT_ON_EBREAK && (instr_in == InstrEbreak);
  assign evt_stuck   = retire && (STUCK_LIMIT != 0) && pc_match && (stuck_inc == STUCK_LIMIT);
  assign evt_timeout = active && (TIMEOUT_CYCLES != 0) && (cycle_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    stuck_d   = stuck_q;
    halt_pc_d = halt_pc_q;
    pulse_d   = 1'b0;
    if (active) begin
      state_d = StRun;
      if (evt_ecall || evt_ebreak || evt_stuck || evt_timeout) begin
        state_d   = StHalted;
        pulse_d   = 1'b1;
        halt_pc_d = retire ? pc_in : prev_pc_q;
        if (evt_ecall) begin
          cause_d = 2'b01;
        end else if (evt_ebreak) begin
          cause_d = 2'b10;
        end else begin
          cause_d = 2'b11;
          stuck_d = evt_stuck;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cycle_q      <= '0;
      instret_q    <= '0;
      wr_ptr_q     <= '0;
      trace_cnt_q  <= '0;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      stuck_cnt_q  <= '0;
      cause_q      <= '0;
      stuck_q      <= 1'b0;
      halt_pc_q    <= '0;
      pulse_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      stuck_q   <= stuck_d;
      halt_pc_q <= halt_pc_d;
      pulse_q   <= pulse_d;
      if (active) begin
        cycle_q <= cycle_inc;
      end
      if (retire) begin
        instret_q    <= instret_q + CNT_W'(1);
        wr_ptr_q     <= wr_ptr_q + IdxW'(1);
        prev_pc_q    <= pc_in;
        prev_valid_q <= 1'b1;
        stuck_cnt_q  <= pc_match ? stuck_inc : 32'd0;
        if (trace_cnt_q != CntW'(TRACE_DEPTH)) begin
          trace_cnt_q <= trace_cnt_q + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (retire) begin
      mem_pc[wr_ptr_q]    <= pc_in;
      mem_instr[wr_ptr_q] <= instr_in;
    end
  end

  // Index 0 is the newest entry, which sits just behind the write pointer
  assign rd_ptr = wr_ptr_q - IdxW'(1) - trace_rd_idx;

  always_comb begin
    trace_rd_pc    = '0;
    trace_rd_instr = '0;
    if ({1'b0, trace_rd_idx} < trace_cnt_q) begin
      trace_rd_pc    = mem_pc[rd_ptr];
      trace_rd_instr = mem_instr[rd_ptr];
    end
  end

  assign trace_count   = trace_cnt_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
  assign running       = (state_q == StRun);
  assign halted        = (state_q == StHalted);
  assign halt_pulse    = pulse_q;
  assign halt_cause    = cause_q;
  assign stuck         = stuck_q;
  assign halt_pc       = halt_pc_q;

endmodule

// File: tb/tb_riscv_sim_monitor.sv
// Bench for riscv_sim_monitor: two instances share stimulus; expected halt records are
// queued when the halting instruction is driven and matched when halt_pulse appears.
module tb_riscv_sim_monitor;

  localparam logic [31:0] Nop    = 32'h0000_0013;
  localparam logic [31:0] Ecall  = 32'h0000_0073;
  localparam logic [31:0] Ebreak = 32'h0010_0073;

  typedef struct packed {
    logic [1:0]  cause;
    logic        stk;
    logic [31:0] pc;
    logic [31:0] instret;
    logic [31:0] cycles;
  } halt_t;

  logic        clk = 1'b0;
  logic        reset, enable, instr_valid;
  logic [31:0] pc_in, instr_in;
  logic [3:0]  trace_rd_idx;

  logic [31:0] m_rd_pc, m_rd_instr, m_cycle, m_instret, m_halt_pc;
  logic [4:0]  m_tcount;
  logic        m_running, m_halted, m_pulse, m_stuck;
  logic [1:0]  m_cause;

  logic [31:0] w_rd_pc, w_rd_instr, w_cycle, w_instret, w_halt_pc;
  logic [4:0]  w_tcount;
  logic        w_running, w_halted, w_pulse, w_stuck;
  logic [1:0]  w_cause;

  int    n_checks = 0;
  int    n_fail   = 0;
  bit    wd_mon   = 1'b0;
  halt_t q_m[$];
  halt_t q_w[$];

  always #5 clk = ~clk;

  riscv_sim_monitor #(
    .TIMEOUT_CYCLES (100000),
    .STUCK_LIMIT    (4),
    .HALT_ON_EBREAK (1'b0)
  ) dut_main (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .instr_valid    (instr_valid),
    .pc_in          (pc_in),
    .instr_in       (instr_in),
    .trace_rd_idx   (trace_rd_idx),
    .trace_rd_pc    (m_rd_pc),
    .trace_rd_instr (m_rd_instr),
    .trace_count    (m_tcount),
    .cycle_count    (m_cycle),
    .instret_count  (m_instret),
    .running        (m_running),
    .halted         (m_halted),
    .halt_pulse     (m_pulse),
    .halt_cause     (m_cause),
    .stuck          (m_stuck),
    .halt_pc        (m_halt_pc)
  );

  riscv_sim_monitor #(
    .TIMEOUT_CYCLES (10)
  ) dut_wd (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .instr_valid    (instr_valid),
    .pc_in          (pc_in),
    .instr_in       (instr_in),
    .trace_rd_idx   (trace_rd_idx),
    .trace_rd_pc    (w_rd_pc),
    .trace_rd_instr (w_rd_instr),
    .trace_count    (w_tcount),
    .cycle_count    (w_cycle),
    .instret_count  (w_instret),
    .running        (w_running),
    .halted         (w_halted),
    .halt_pulse     (w_pulse),
    .halt_cause     (w_cause),
    .stuck          (w_stuck),
    .halt_pc        (w_halt_pc)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_match(input string who, input halt_t e, input logic [1:0] cause,
                          input logic stk, input logic [31:0] pc, input logic [31:0] ir,
                          input logic [31:0] cy);
    check_eq({who, "_cause"}, cause, e.cause);
    check_eq({who, "_stuck"}, stk, e.stk);
    check_eq({who, "_halt_pc"}, pc, e.pc);
    check_eq({who, "_instret"}, ir, e.instret);
    check_eq({who, "_cycles"}, cy, e.cycles);
    check_eq({who, "_halted_with_pulse"}, {31'd0, (cause != 2'b00)}, 64'd1);
  endtask

  task automatic step(input logic en, input logic v, input logic [31:0] pc,
                      input logic [31:0] ins);
    halt_t e;
    enable      = en;
    instr_valid = v;
    pc_in       = pc;
    instr_in    = ins;
    @(posedge clk);
    #1;
    if (m_pulse) begin
      if (q_m.size() == 0) check_eq("main_spurious_pulse", m_pulse, 0);
      else begin
        e = q_m.pop_front();
        sb_match("main", e, m_cause, m_stuck, m_halt_pc, m_instret, m_cycle);
      end
    end
    if (wd_mon && w_pulse) begin
      if (q_w.size() == 0) check_eq("wd_spurious_pulse", w_pulse, 0);
      else begin
        e = q_w.pop_front();
        sb_match("wd", e, w_cause, w_stuck, w_halt_pc, w_instret, w_cycle);
      end
    end
  endtask

  task automatic end_test(input string name);
    check_eq({name, "_main_halts_seen"}, q_m.size(), 0);
    check_eq({name, "_wd_halts_seen"}, q_w.size(), 0);
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    enable       = 1'b0;
    instr_valid  = 1'b0;
    pc_in        = '0;
    instr_in     = '0;
    trace_rd_idx = '0;
    wd_mon       = 1'b0;
    q_m.delete();
    q_w.delete();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_halted", m_halted, 0);
    check_eq("rst_running", m_running, 0);
    check_eq("rst_pulse", m_pulse, 0);
    check_eq("rst_cycle", m_cycle, 0);
    check_eq("rst_instret", m_instret, 0);
    check_eq("rst_tcount", m_tcount, 0);
    check_eq("rst_cause", m_cause, 0);
    check_eq("rst_halt_pc", m_halt_pc, 0);
    check_eq("rst_stuck", m_stuck, 0);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    // ECALL halt with trace readback and out-of-range index
    do_reset();
    step(1, 1, 0, Nop);
    step(1, 1, 4, Nop);
    step(1, 1, 8, Nop);
    q_m.push_back('{cause: 2'b01, stk: 1'b0, pc: 12, instret: 4, cycles: 4});
    step(1, 1, 12, Ecall);
    step(1, 1, 16, Nop);
    check_eq("ecall_pulse_one_cycle", m_pulse, 0);
    check_eq("ecall_halted_sticky", m_halted, 1);
    check_eq("ecall_cycle_frozen", m_cycle, 4);
    check_eq("ecall_instret_frozen", m_instret, 4);
    check_eq("ecall_tcount", m_tcount, 4);
    trace_rd_idx = 0; #1;
    check_eq("ecall_tr0_pc", m_rd_pc, 12);
    check_eq("ecall_tr0_instr", m_rd_instr, Ecall);
    trace_rd_idx = 3; #1;
    check_eq("ecall_tr3_pc", m_rd_pc, 0);
    trace_rd_idx = 4; #1;
    check_eq("ecall_tr4_pc_zero", m_rd_pc, 0);
    check_eq("ecall_tr4_instr_zero", m_rd_instr, 0);
    end_test("ecall");

    // Trace wrap after 20 retirements
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 1, 32'(4 * i), Nop + (32'(i) << 20));
    check_eq("wrap_tcount", m_tcount, 16);
    check_eq("wrap_instret", m_instret, 20);
    check_eq("wrap_running", m_running, 1);
    trace_rd_idx = 0; #1;
    check_eq("wrap_tr0_pc", m_rd_pc, 76);
    check_eq("wrap_tr0_instr", m_rd_instr, Nop + (32'd19 << 20));
    trace_rd_idx = 15; #1;
    check_eq("wrap_tr15_pc", m_rd_pc, 16);
    check_eq("wrap_tr15_instr", m_rd_instr, Nop + (32'd4 << 20));
    end_test("wrap");

    // Watchdog timeout, then everything frozen
    do_reset();
    wd_mon = 1'b1;
    q_w.push_back('{cause: 2'b11, stk: 1'b0, pc: 36, instret: 10, cycles: 10});
    for (int i = 0; i < 15; i++) step(1, 1, 32'(4 * i), Nop);
    check_eq("tmo_cycle_frozen", w_cycle, 10);
    check_eq("tmo_instret_frozen", w_instret, 10);
    check_eq("tmo_tcount_frozen", w_tcount, 10);
    check_eq("tmo_halted", w_halted, 1);
    check_eq("tmo_running", w_running, 0);
    end_test("tmo");

    // Stuck PC: halts on the 5th retirement at 0x20
    do_reset();
    q_m.push_back('{cause: 2'b11, stk: 1'b1, pc: 32'h20, instret: 6, cycles: 6});
    step(1, 1, 32'h10, Nop);
    for (int i = 0; i < 5; i++) step(1, 1, 32'h20, Nop);
    step(1, 1, 32'h24, Nop);
    check_eq("stuck_halted", m_halted, 1);
    check_eq("stuck_instret", m_instret, 6);
    end_test("stuck");

    // ECALL on the timeout cycle wins
    do_reset();
    wd_mon = 1'b1;
    q_w.push_back('{cause: 2'b01, stk: 1'b0, pc: 36, instret: 10, cycles: 10});
    q_m.push_back('{cause: 2'b01, stk: 1'b0, pc: 36, instret: 10, cycles: 10});
    for (int i = 0; i < 9; i++) step(1, 1, 32'(4 * i), Nop);
    step(1, 1, 36, Ecall);
    end_test("prio");

    // EBREAK ignored on main, halts the instance that honours it
    do_reset();
    wd_mon = 1'b1;
    q_w.push_back('{cause: 2'b10, stk: 1'b0, pc: 4, instret: 2, cycles: 2});
    step(1, 1, 0, Nop);
    step(1, 1, 4, Ebreak);
    step(1, 1, 8, Nop);
    check_eq("ebreak_instret", m_instret, 3);
    check_eq("ebreak_not_halted", m_halted, 0);
    check_eq("ebreak_running", m_running, 1);
    check_eq("ebreak_cause_none", m_cause, 0);
    end_test("ebreak");

    // Pause, halt, then reset while halted
    do_reset();
    step(1, 1, 0, Nop);
    step(1, 1, 4, Nop);
    step(1, 1, 8, Nop);
    for (int i = 0; i < 3; i++) step(0, 1, 32'(32'h100 + 4 * i), Nop);
    check_eq("pause_cycle", m_cycle, 3);
    check_eq("pause_instret", m_instret, 3);
    check_eq("pause_tcount", m_tcount, 3);
    check_eq("pause_running", m_running, 1);
    trace_rd_idx = 0; #1;
    check_eq("pause_tr0_pc", m_rd_pc, 8);
    step(1, 1, 12, Nop);
    check_eq("resume_cycle", m_cycle, 4);
    q_m.push_back('{cause: 2'b01, stk: 1'b0, pc: 16, instret: 5, cycles: 5});
    step(1, 1, 16, Ecall);
    end_test("pause");
    reset = 1'b0;
    #2;
    check_eq("async_rst_halted", m_halted, 0);
    check_eq("async_rst_pulse", m_pulse, 0);
    check_eq("async_rst_cycle", m_cycle, 0);
    check_eq("async_rst_cause", m_cause, 0);
    check_eq("async_rst_halt_pc", m_halt_pc, 0);
    check_eq("async_rst_running", m_running, 0);
    @(negedge clk);
    reset = 1'b1;
    step(1, 1, 0, Nop);
    check_eq("restart_cycle", m_cycle, 1);
    check_eq("restart_instret", m_instret, 1);
    check_eq("restart_running", m_running, 1);
    end_test("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
